// File: rtl/mul_share_ctrl.sv
// Round-robin controller that shares one 8x8 signed Booth multiplier between
// NREQ requesters: accepts an operand pair, pulses the multiplier start, captures
// the product on the first cycle busy drops, and returns it to the owner.
module mul_share_ctrl #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TMO  = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_mc,
  input  logic [8*NREQ-1:0]   req_mp,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [15:0]         rsp_prod,
  output logic                rsp_err,
  output logic                mul_start,
  output logic [7:0]          mul_mc,
  output logic [7:0]          mul_mp,
  input  logic [15:0]         mul_prod,
  input  logic                mul_busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned TW  = 4;
  localparam logic [TW-1:0] TMR_LAST = TW'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id;
  logic [TW-1:0]   tmr;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt;
  logic [7:0]      gnt_mc;
  logic [7:0]      gnt_mp;

  // Round-robin search starting just after the last served requester
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      logic [IDW-1:0] j;
      j = IDW'((32'(ptr) + k) % NREQ);
      if (!gnt_vld && req_valid[j]) begin
        gnt_vld = 1'b1;
        gnt     = j;
      end
    end
    gnt_mc = req_mc[{gnt, 3'b000} +: 8];
    gnt_mp = req_mp[{gnt, 3'b000} +: 8];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a busy-low sample wins over a coincident timeout
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (gnt_vld) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT:   if (!mul_busy || (tmr == TMR_LAST)) state_nx = S_RESP;
      S_RESP:   if (rsp_ready[id]) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Handshake strobes and the one-cycle multiplier load pulse
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    case (state)
      S_IDLE:   if (gnt_vld) req_ready[gnt] = 1'b1;
      S_LAUNCH: mul_start = 1'b1;
      S_RESP:   rsp_valid[id] = 1'b1;
      default:  ;
    endcase
  end

  // Operand capture, timer, product capture and priority pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= IDW'(NREQ - 1);
      id       <= '0;
      tmr      <= '0;
      mul_mc   <= '0;
      mul_mp   <= '0;
      rsp_prod <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            mul_mc <= gnt_mc;
            mul_mp <= gnt_mp;
            id     <= gnt;
          end
        end
        S_LAUNCH: tmr <= '0;
        S_WAIT: begin
          tmr <= tmr + TW'(1);
          // The multiplier keeps stepping, so only the first busy-low sample is valid
          if (!mul_busy) begin
            rsp_prod <= mul_prod;
            rsp_err  <= 1'b0;
          end else if (tmr == TMR_LAST) begin
            rsp_prod <= '0;
            rsp_err  <= 1'b1;
          end
        end
        S_RESP: if (rsp_ready[id]) ptr <= id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl with a behavioural stepping multiplier.
module tb_mul_share_ctrl;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TMO  = 12;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_mc;
  logic [8*NREQ-1:0] req_mp;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [15:0]       rsp_prod;
  logic              rsp_err;
  logic              mul_start;
  logic [7:0]        mul_mc;
  logic [7:0]        mul_mp;
  logic [15:0]       mul_prod;
  logic              mul_busy;

  mul_share_ctrl #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mc    (req_mc),
    .req_mp    (req_mp),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_mc    (mul_mc),
    .mul_mp    (mul_mp),
    .mul_prod  (mul_prod),
    .mul_busy  (mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: loads on start, steps every cycle with a wrapping
  // 4-bit count, product only correct while the count is exactly 8.
  logic              stuck = 1'b0;
  logic [3:0]        m_cnt = 4'd8;
  logic [7:0]        m_a = 8'd0;
  logic [7:0]        m_b = 8'd0;
  logic signed [15:0] m_true;

  always @(posedge clk) begin
    if (mul_start) begin
      m_a   <= mul_mc;
      m_b   <= mul_mp;
      m_cnt <= 4'd0;
    end else begin
      m_cnt <= m_cnt + 4'd1;
    end
  end

  assign m_true   = $signed(m_a) * $signed(m_b);
  assign mul_busy = stuck | (m_cnt < 4'd8);
  assign mul_prod = (m_cnt == 4'd8) ? m_true : (m_true ^ 16'hA5A5);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          id;
    logic [15:0] prod;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  // Monitor state
  exp_t            mon_e;
  logic            in_flight = 1'b0;
  logic            prev_valid = 1'b0;
  logic            prev_start = 1'b0;
  logic [NREQ-1:0] h_valid;
  logic [15:0]     h_prod;
  logic            h_err;
  int              cur_lat = 0;

  // Monitor: accept/start timing, response stability and scoreboard compare
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      in_flight  = 1'b0;
      prev_valid = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (|(req_ready & req_valid)) begin
        chk("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("accept_while_busy", 32'(in_flight), 32'd0);
        acc_q.push_back(cyc + 1);
        in_flight = 1'b1;
      end
      if (mul_start) begin
        chk("start_double", 32'(prev_start), 32'd0);
        chk("start_timing", 32'((acc_q.size() > 0) && (acc_q[$] == cyc)), 32'd1);
      end
      prev_start = mul_start;
      if (|rsp_valid) begin
        if (!prev_valid) begin
          chk("rsp_valid_onehot", 32'($onehot(rsp_valid)), 32'd1);
          if (acc_q.size() == 0) begin
            chk("rsp_without_accept", 32'd1, 32'd0);
            cur_lat = -1;
          end else begin
            cur_lat = cyc - acc_q.pop_front();
          end
          h_valid = rsp_valid;
          h_prod  = rsp_prod;
          h_err   = rsp_err;
        end else begin
          chk("hold_valid", 32'(rsp_valid), 32'(h_valid));
          chk("hold_prod", 32'(rsp_prod), 32'(h_prod));
          chk("hold_err", 32'(rsp_err), 32'(h_err));
        end
        if (|(rsp_valid & rsp_ready)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_owner", 32'(rsp_valid), 32'(1 << mon_e.id));
            chk("rsp_prod", 32'(rsp_prod), 32'(mon_e.prod));
            chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            chk("rsp_latency", 32'(cur_lat), 32'(mon_e.lat));
          end
          in_flight = 1'b0;
        end
      end
      prev_valid = |rsp_valid;
    end
  end

  task automatic push_exp(input int r, input logic [15:0] p, input logic e, input int lat);
    exp_t x;
    x.id = r; x.prod = p; x.err = e; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic set_ops(input int r, input logic [7:0] mc, input logic [7:0] mp);
    req_mc[8*r +: 8] = mc;
    req_mp[8*r +: 8] = mp;
  endtask

  // Wait (bounded) for requester r to be accepted; returns just after the accept edge
  task automatic wait_accept(input int r);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[r] && req_valid[r]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'(r), 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input logic [7:0] mc, input logic [7:0] mp,
                      input logic [15:0] p, input logic e, input int lat);
    push_exp(r, p, e, lat);
    set_ops(r, mc, mp);
    req_valid[r] = 1'b1;
    wait_accept(r);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_mc    = '0;
    req_mp    = '0;
    rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mul_mc", 32'(mul_mc), 32'd0);
    chk("rst_mul_mp", 32'(mul_mp), 32'd0);
    chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;

    // Basic transaction and corner operands
    send(0, 8'hFD, 8'h07, 16'hFFEB, 1'b0, 10);
    wait_done();
    send(0, 8'h80, 8'h80, 16'h4000, 1'b0, 10);
    wait_done();
    send(0, 8'h7F, 8'h7F, 16'h3F01, 1'b0, 10);
    wait_done();
    send(0, 8'h80, 8'h7F, 16'hC080, 1'b0, 10);
    wait_done();
    send(0, 8'h00, 8'hA5, 16'h0000, 1'b0, 10);
    wait_done();

    // All requesters valid: grant order 0,1,2,3,0 (ptr is back at 0 here, so
    // re-reset to restart the rotation from requester 0)
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_ops(0, 8'h02, 8'h03);
    set_ops(1, 8'hFF, 8'hFF);
    set_ops(2, 8'h10, 8'hF0);
    set_ops(3, 8'h0A, 8'h0A);
    push_exp(0, 16'h0006, 1'b0, 10);
    push_exp(1, 16'h0001, 1'b0, 10);
    push_exp(2, 16'hFF00, 1'b0, 10);
    push_exp(3, 16'h0064, 1'b0, 10);
    push_exp(0, 16'h0006, 1'b0, 10);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_accept(order[k]);
      if (k != 0) req_valid[order[k]] = 1'b0;
    end
    wait_done();

    // Response back-pressure for 20 cycles, then rotation past the owner
    rsp_ready = '0;
    send(1, 8'h03, 8'h04, 16'h000C, 1'b0, 10);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) break;
    end
    @(posedge clk);
    #1;
    set_ops(2, 8'hF0, 8'h10);
    set_ops(1, 8'h06, 8'hF9);
    push_exp(2, 16'hFF00, 1'b0, 10);
    push_exp(1, 16'hFFD6, 1'b0, 10);
    req_valid[2] = 1'b1;
    req_valid[1] = 1'b1;
    repeat (20) @(posedge clk);
    #1 rsp_ready = '1;
    wait_accept(2);
    req_valid[2] = 1'b0;
    wait_accept(1);
    req_valid[1] = 1'b0;
    wait_done();

    // Multiplier never finishes: timeout response
    stuck = 1'b1;
    send(3, 8'h11, 8'h22, 16'h0000, 1'b1, 13);
    wait_done();
    stuck = 1'b0;

    // Reset during the fourth WAIT cycle drops the transaction
    set_ops(0, 8'h40, 8'h02);
    req_valid[0] = 1'b1;
    wait_accept(0);
    req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_mul_start", 32'(mul_start), 32'd0);
    chk("mid_rst_mul_mc", 32'(mul_mc), 32'd0);
    chk("mid_rst_mul_mp", 32'(mul_mp), 32'd0);
    chk("mid_rst_rsp_prod", 32'(rsp_prod), 32'd0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (15) @(negedge clk);
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    send(0, 8'h05, 8'hFE, 16'hFFF6, 1'b0, 10);
    wait_done();

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
